// File: rtl/xgmii_pkg.sv
// Shared XGMII control characters, CRC-32 constants and transmit FSM state type.
package xgmii_pkg;

  localparam logic [7:0]  XGMII_IDLE  = 8'h07;
  localparam logic [7:0]  XGMII_START = 8'hFB;
  localparam logic [7:0]  XGMII_TERM  = 8'hFD;
  localparam logic [7:0]  XGMII_ERR   = 8'hFE;

  localparam logic [31:0] CRC32_POLY  = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT  = 32'hFFFFFFFF;

  localparam logic [63:0] IDLE_WORD   = {8{XGMII_IDLE}};
  localparam logic [63:0] ERR_WORD    = {8{XGMII_ERR}};

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    TAIL,
    IPG
  } tx_state_t;

endpackage

// File: rtl/crc32_d64.sv
// Combinational reflected CRC-32 update over the first nbytes (0..8) of a 64-bit word.
module crc32_d64
  import xgmii_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [63:0] data,
  input  logic [3:0]  nbytes,
  output logic [31:0] crc_out
);

  logic [31:0] crc_acc;

  // Byte 0 is the first on the wire and sits in the top byte of data.
  always_comb begin
    crc_acc = crc_in;
    for (int b = 0; b < 8; b++) begin
      if (4'(b) < nbytes) begin
        crc_acc = crc_acc ^ {24'h0, data[63-8*b -: 8]};
        for (int i = 0; i < 8; i++) begin
          crc_acc = crc_acc[0] ? ((crc_acc >> 1) ^ CRC32_POLY) : (crc_acc >> 1);
        end
      end
    end
    crc_out = crc_acc;
  end

endmodule

// File: rtl/xgmii_tx_encoder.sv
// Maps MAC frame words onto 64-bit XGMII TX: /S/ insertion, CRC-32 FCS append, /T/ and IPG.
module xgmii_tx_encoder
  import xgmii_pkg::*;
#(
  parameter int unsigned MIN_IPG_BYTES = 12,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  input  logic [63:0]          i_data,
  input  logic                 i_last,
  input  logic [2:0]           i_last_bytes,
  output logic                 o_ready,
  output logic [63:0]          o_txd,
  output logic [7:0]           o_txc,
  output logic                 o_underrun,
  output logic [CNT_WIDTH-1:0] o_frame_cnt
);

  localparam logic [15:0] MinIpg = 16'(MIN_IPG_BYTES);

  tx_state_t            state_q, state_d;
  logic [63:0]          txd_q, txd_d;
  logic [7:0]           txc_q, txc_d;
  logic [63:0]          tail_txd_q, tail_txd_d;
  logic [7:0]           tail_txc_q, tail_txc_d;
  logic                 ready_q, ready_d;
  logic                 underrun_q, underrun_d;
  logic [CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
  logic [31:0]          crc_q, crc_d;
  logic [15:0]          ipg_cnt_q, ipg_cnt_d;

  logic                 xfer;
  logic [3:0]           last_k;
  logic [4:0]           last_kx;
  logic [3:0]           crc_nbytes;
  logic [31:0]          crc_next;
  logic [31:0]          fcs;
  logic [63:0]          data_lanes;
  logic [127:0]         data_ext;
  logic [127:0]         end_txd;
  logic [15:0]          end_txc;
  logic                 enter_ipg;
  logic [15:0]          ipg_seed;

  assign xfer       = i_valid & ready_q;
  assign last_k     = (i_last_bytes == 3'd0) ? 4'd8 : {1'b0, i_last_bytes};
  assign last_kx    = {1'b0, last_k};
  assign crc_nbytes = i_last ? last_k : 4'd8;
  assign fcs        = ~crc_next;

  // Wire-order byte n of the input lands on XGMII lane n.
  always_comb begin
    data_lanes = '0;
    for (int n = 0; n < 8; n++) begin
      data_lanes[8*n +: 8] = i_data[63-8*n -: 8];
    end
  end

  assign data_ext = {IDLE_WORD, data_lanes};

  crc32_d64 u_crc (
    .crc_in  (crc_q),
    .data    (i_data),
    .nbytes  (crc_nbytes),
    .crc_out (crc_next)
  );

  // Two-word view of the frame end: data, FCS (LSB byte first), /T/, then /I/ fill.
  always_comb begin
    end_txd = {2{IDLE_WORD}};
    end_txc = '1;
    for (int n = 0; n < 16; n++) begin
      if (5'(n) < last_kx) begin
        end_txd[8*n +: 8] = data_ext[8*n +: 8];
        end_txc[n]        = 1'b0;
      end else if (5'(n) < last_kx + 5'd4) begin
        end_txc[n] = 1'b0;
        case (5'(n) - last_kx)
          5'd0:    end_txd[8*n +: 8] = fcs[7:0];
          5'd1:    end_txd[8*n +: 8] = fcs[15:8];
          5'd2:    end_txd[8*n +: 8] = fcs[23:16];
          default: end_txd[8*n +: 8] = fcs[31:24];
        endcase
      end else if (5'(n) == last_kx + 5'd4) begin
        end_txd[8*n +: 8] = XGMII_TERM;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    txd_d       = IDLE_WORD;
    txc_d       = 8'hFF;
    tail_txd_d  = tail_txd_q;
    tail_txc_d  = tail_txc_q;
    ready_d     = ready_q;
    underrun_d  = 1'b0;
    frame_cnt_d = frame_cnt_q;
    crc_d       = crc_q;
    ipg_cnt_d   = ipg_cnt_q;
    enter_ipg   = 1'b0;
    ipg_seed    = '0;

    unique case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (xfer) begin
          txd_d   = {data_lanes[63:8], XGMII_START};
          txc_d   = 8'h01;
          crc_d   = CRC32_INIT;
          state_d = DATA;
        end
      end
      DATA: begin
        if (!i_valid) begin
          txd_d      = ERR_WORD;
          txc_d      = 8'hFF;
          underrun_d = 1'b1;
          enter_ipg  = 1'b1;
          ipg_seed   = 16'd0;
        end else if (xfer) begin
          crc_d = crc_next;
          if (!i_last) begin
            txd_d = data_lanes;
            txc_d = 8'h00;
          end else begin
            txd_d = end_txd[63:0];
            txc_d = end_txc[7:0];
            if (last_k <= 4'd3) begin
              frame_cnt_d = frame_cnt_q + 1'b1;
              enter_ipg   = 1'b1;
              ipg_seed    = 16'(4'd3 - last_k);
            end else begin
              // /T/ spills into the next word; seed the idle count it will leave behind.
              tail_txd_d = end_txd[127:64];
              tail_txc_d = end_txc[15:8];
              ipg_cnt_d  = 16'(4'd11 - last_k);
              ready_d    = 1'b0;
              state_d    = TAIL;
            end
          end
        end
      end
      TAIL: begin
        txd_d       = tail_txd_q;
        txc_d       = tail_txc_q;
        frame_cnt_d = frame_cnt_q + 1'b1;
        enter_ipg   = 1'b1;
        ipg_seed    = ipg_cnt_q;
      end
      IPG: begin
        enter_ipg = 1'b1;
        ipg_seed  = ipg_cnt_q + 16'd8;
      end
      default: state_d = IDLE;
    endcase

    // Ready rises together with the output word that completes the gap.
    if (enter_ipg) begin
      ipg_cnt_d = ipg_seed;
      if (ipg_seed >= MinIpg) begin
        ready_d = 1'b1;
        state_d = IDLE;
      end else begin
        ready_d = 1'b0;
        state_d = IPG;
      end
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      txd_q       <= IDLE_WORD;
      txc_q       <= 8'hFF;
      tail_txd_q  <= IDLE_WORD;
      tail_txc_q  <= 8'hFF;
      ready_q     <= 1'b1;
      underrun_q  <= 1'b0;
      frame_cnt_q <= '0;
      crc_q       <= CRC32_INIT;
      ipg_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      txd_q       <= txd_d;
      txc_q       <= txc_d;
      tail_txd_q  <= tail_txd_d;
      tail_txc_q  <= tail_txc_d;
      ready_q     <= ready_d;
      underrun_q  <= underrun_d;
      frame_cnt_q <= frame_cnt_d;
      crc_q       <= crc_d;
      ipg_cnt_q   <= ipg_cnt_d;
    end
  end

  assign o_ready     = ready_q;
  assign o_txd       = txd_q;
  assign o_txc       = txc_q;
  assign o_underrun  = underrun_q;
  assign o_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_xgmii_tx_encoder.sv
// Bench for xgmii_tx_encoder: directed frame-end cases plus randomized frames against a byte-stream model.
module tb_xgmii_tx_encoder;

  localparam int MinIpg = 12;
  localparam logic [63:0] IdleW = {8{8'h07}};

  logic        clk;
  logic        i_rst_n;
  logic        i_valid;
  logic [63:0] i_data;
  logic        i_last;
  logic [2:0]  i_last_bytes;
  logic        o_ready;
  logic [63:0] o_txd;
  logic [7:0]  o_txc;
  logic        o_underrun;
  logic [15:0] o_frame_cnt;

  xgmii_tx_encoder dut (
    .clk          (clk),
    .i_rst_n      (i_rst_n),
    .i_valid      (i_valid),
    .i_data       (i_data),
    .i_last       (i_last),
    .i_last_bytes (i_last_bytes),
    .o_ready      (o_ready),
    .o_txd        (o_txd),
    .o_txc        (o_txc),
    .o_underrun   (o_underrun),
    .o_frame_cnt  (o_frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int frames_done = 0;

  logic [7:0]  pl[$];
  logic [63:0] pre_word;
  logic        pre_last;
  logic [2:0]  pre_lb;
  logic        b2b;
  logic [63:0] seen_txd[$];
  logic [7:0]  seen_txc[$];
  logic        seen_rdy[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Wire byte n of an input word goes to lane n of the output word.
  function automatic logic [63:0] to_lanes(input logic [63:0] w);
    logic [63:0] r;
    for (int n = 0; n < 8; n++) r[8*n +: 8] = w[63-8*n -: 8];
    return r;
  endfunction

  function automatic logic [31:0] crc_of_pl();
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (pl[i]) begin
      c = c ^ {24'h0, pl[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  task automatic new_preamble();
    pre_word = {$urandom, $urandom};
    pre_last = 1'($urandom_range(0, 1));
    pre_lb   = 3'($urandom_range(0, 7));
  endtask

  task automatic rand_payload(input int len);
    pl.delete();
    for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
  endtask

  // Sends pre_word + pl, checking every output word against the byte-stream model.
  task automatic run_frame(input string tag);
    logic [63:0] in_d[$];
    logic        in_l[$];
    logic [2:0]  in_lb[$];
    logic [63:0] ex_d[$];
    logic [7:0]  ex_c[$];
    logic        ex_r[$];
    logic [7:0]  bs[$];
    logic        bc[$];
    logic [63:0] wd;
    logic [7:0]  wc;
    logic [31:0] fcs;
    logic        rdy_prev;
    int len, w, m, idles, ip;

    seen_txd.delete(); seen_txc.delete(); seen_rdy.delete();
    len = pl.size();
    w   = (len + 7) / 8;

    in_d.push_back(pre_word); in_l.push_back(pre_last); in_lb.push_back(pre_lb);
    for (int i = 0; i < w; i++) begin
      wd = {$urandom, $urandom};
      for (int b = 0; b < 8; b++) if (8*i + b < len) wd[63-8*b -: 8] = pl[8*i + b];
      in_d.push_back(wd);
      in_l.push_back(i == w - 1);
      in_lb.push_back((i == w - 1) ? 3'((len - 8*i) % 8) : 3'($urandom_range(0, 7)));
    end

    wd = to_lanes(pre_word);
    wd[7:0] = 8'hFB;
    ex_d.push_back(wd); ex_c.push_back(8'h01); ex_r.push_back(1'b1);

    fcs = ~crc_of_pl();
    foreach (pl[i]) begin bs.push_back(pl[i]); bc.push_back(1'b0); end
    for (int j = 0; j < 4; j++) begin bs.push_back(fcs[8*j +: 8]); bc.push_back(1'b0); end
    bs.push_back(8'hFD); bc.push_back(1'b1);
    while (bs.size() % 8 != 0) begin bs.push_back(8'h07); bc.push_back(1'b1); end
    m = bs.size() / 8;
    for (int j = 0; j < m; j++) begin
      for (int n = 0; n < 8; n++) begin wd[8*n +: 8] = bs[8*j + n]; wc[n] = bc[8*j + n]; end
      ex_d.push_back(wd); ex_c.push_back(wc); ex_r.push_back(j < w - 1);
    end
    idles = 7 - ((len + 4) % 8);
    while (idles < MinIpg) begin
      idles += 8;
      ex_d.push_back(IdleW); ex_c.push_back(8'hFF); ex_r.push_back(idles >= MinIpg);
    end

    new_preamble();
    ip = 0;
    rdy_prev = 1'b1;
    for (int op = 0; op < ex_d.size(); op++) begin
      if (ip < in_d.size()) begin
        i_valid = 1'b1; i_data = in_d[ip]; i_last = in_l[ip]; i_last_bytes = in_lb[ip];
      end else if (b2b) begin
        i_valid = 1'b1; i_data = pre_word; i_last = pre_last; i_last_bytes = pre_lb;
      end else begin
        i_valid = 1'b0; i_data = {$urandom, $urandom}; i_last = 1'b0; i_last_bytes = 3'd0;
      end
      if (rdy_prev && ip < in_d.size()) ip++;
      tick();
      chk($sformatf("%s txd[%0d]", tag, op), o_txd, ex_d[op]);
      chk($sformatf("%s txc[%0d]", tag, op), 64'(o_txc), 64'(ex_c[op]));
      chk($sformatf("%s ready[%0d]", tag, op), 64'(o_ready), 64'(ex_r[op]));
      chk($sformatf("%s underrun[%0d]", tag, op), 64'(o_underrun), 64'd0);
      seen_txd.push_back(o_txd); seen_txc.push_back(o_txc); seen_rdy.push_back(o_ready);
      rdy_prev = ex_r[op];
    end
    frames_done++;
    chk($sformatf("%s frame_cnt", tag), 64'(o_frame_cnt), 64'(16'(frames_done)));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      i_valid = 1'b0;
      tick();
      chk("idle txd", o_txd, IdleW);
      chk("idle ready", 64'(o_ready), 64'd1);
    end
  endtask

  initial begin
    logic [63:0] d1;
    i_rst_n = 1'b1; i_valid = 1'b0; i_data = '0; i_last = 1'b0; i_last_bytes = 3'd0;
    b2b = 1'b0;
    #2 i_rst_n = 1'b0;
    #1;
    chk("reset txd", o_txd, IdleW);
    chk("reset txc", 64'(o_txc), 64'hFF);
    chk("reset ready", 64'(o_ready), 64'd1);
    chk("reset underrun", 64'(o_underrun), 64'd0);
    chk("reset frame_cnt", 64'(o_frame_cnt), 64'd0);
    tick(); tick();
    i_rst_n = 1'b1;
    idle_cycles(2);

    // Known-answer frame: payload "123456789", FCS CBF43926.
    pre_word = 64'h55555555555555D5; pre_last = 1'b0; pre_lb = 3'd0;
    pl.delete();
    for (int i = 0; i < 9; i++) pl.push_back(8'h31 + 8'(i));
    run_frame("kat");
    chk("kat out0", seen_txd[0], 64'hD5555555555555FB);
    chk("kat out2", seen_txd[2], 64'h0707FDCBF4392639);
    chk("kat txc2", 64'(seen_txc[2]), 64'hE0);
    chk("kat words", 64'(seen_txd.size()), 64'd5);

    // Full last word: FCS and /T/ spill into the next word.
    rand_payload(16);
    run_frame("k8");
    chk("k8 spill txc", 64'(seen_txc[3]), 64'hF0);
    chk("k8 spill ready", 64'(seen_rdy[3]), 64'd0);

    // Three bytes in the last word: /T/ lands in lane 7, two idle words follow.
    rand_payload(11);
    run_frame("k3");
    chk("k3 txc", 64'(seen_txc[2]), 64'h80);
    chk("k3 idle words", 64'(seen_txd.size() - 3), 64'd2);
    idle_cycles(1);

    // Underrun: valid drops mid-frame.
    new_preamble();
    d1 = {$urandom, $urandom};
    i_valid = 1'b1; i_data = pre_word; i_last = 1'b0; i_last_bytes = 3'd0;
    tick();
    chk("ur start txc", 64'(o_txc), 64'h01);
    i_data = d1;
    tick();
    chk("ur data txd", o_txd, to_lanes(d1));
    chk("ur data txc", 64'(o_txc), 64'h00);
    i_valid = 1'b0;
    tick();
    chk("ur err txd", o_txd, {8{8'hFE}});
    chk("ur err txc", 64'(o_txc), 64'hFF);
    chk("ur pulse", 64'(o_underrun), 64'd1);
    chk("ur err ready", 64'(o_ready), 64'd0);
    tick();
    chk("ur pulse end", 64'(o_underrun), 64'd0);
    chk("ur ipg1 txd", o_txd, IdleW);
    chk("ur ipg1 ready", 64'(o_ready), 64'd0);
    tick();
    chk("ur ipg2 txd", o_txd, IdleW);
    chk("ur ipg2 ready", 64'(o_ready), 64'd1);
    chk("ur frame_cnt", 64'(o_frame_cnt), 64'(16'(frames_done)));
    rand_payload(13);
    run_frame("post_ur");

    // Reset mid-payload, then a fresh frame must carry a correct FCS.
    new_preamble();
    i_valid = 1'b1; i_data = pre_word; i_last = 1'b0;
    tick();
    i_data = {$urandom, $urandom};
    tick();
    i_data = {$urandom, $urandom};
    #2 i_rst_n = 1'b0;
    #1;
    chk("mid rst txd", o_txd, IdleW);
    chk("mid rst txc", 64'(o_txc), 64'hFF);
    chk("mid rst ready", 64'(o_ready), 64'd1);
    chk("mid rst frame_cnt", 64'(o_frame_cnt), 64'd0);
    frames_done = 0;
    tick();
    i_valid = 1'b0;
    i_rst_n = 1'b1;
    idle_cycles(1);
    rand_payload(21);
    run_frame("post_rst");

    // Randomized frames, mostly back-to-back with valid held high through the gap.
    for (int f = 0; f < 24; f++) begin
      b2b = ($urandom_range(0, 3) != 0);
      rand_payload(8 * $urandom_range(0, 4) + $urandom_range(1, 8));
      run_frame($sformatf("rnd%0d", f));
      if (!b2b) idle_cycles($urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
